clk_div_sched: RTL and testbench



---
 rtl/clk_div_sched.sv | 177 +++++++++++++++++
 tb/tb_clk_div_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
//-----------------------------------------------------------------------------
// clk_div_sched
//
// Runtime-programmable integer clock divider with a small scheduler that owns
// ratio changes and start/stop sequencing. A new ratio is accepted over a
// valid/ready handshake and applied only at an output-period boundary. The
// divided clock never shows a runt pulse. Duty is 50% for even and odd ratios:
// a posedge register p is ORed with a negedge copy q when the ratio is odd.
//
// Parameters:
//   DIV_W        width of the divide-ratio field
//   DEFAULT_DIV  ratio loaded at reset (2 .. 2**DIV_W-1)
//
// Ports:
//   i_clk         source clock
//   i_rst_n       asynchronous active-low reset
//   i_en          1 = run the divided clock, 0 = stop at the next boundary
//   i_cfg_valid   a new ratio is offered
//   i_cfg_div     offered ratio N
//   o_cfg_ready   scheduler can accept a ratio
//   o_cfg_err     one-cycle pulse: the offered ratio was illegal (< 2)
//   o_busy        a ratio change is pending
//   o_div_cur     ratio currently in effect
//   o_period_stb  one-cycle pulse aligned to each rising edge of o_clk_div
//                 (present only when CLK_DIV_STROBE_EN is defined)
//   o_clk_div     divided clock
//
// Build option: define CLK_DIV_STROBE_EN to add o_period_stb.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module clk_div_sched #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_busy,
  output logic [DIV_W-1:0] o_div_cur,
`ifdef CLK_DIV_STROBE_EN
  output logic             o_period_stb,
`endif
  output logic             o_clk_div
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SWITCH
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_cur_q;
  logic [DIV_W-1:0] pend_div_q;
  logic             pend_q;
  logic             err_q;
  logic             p_q;
  logic             q_q;

  logic [DIV_W-1:0] half_w;
  logic             cnt_last;
  logic             cfg_fire;
  logic             cfg_illegal;

  // floor(N/2) is the high time of p for both even and odd N; the odd half
  // cycle comes from the negedge register.
  assign half_w      = div_cur_q >> 1;
  assign cnt_last    = (cnt_q == div_cur_q - DIV_W'(1));
  assign o_cfg_ready = ~pend_q & (state_q != ST_SWITCH);
  assign cfg_fire    = i_cfg_valid & o_cfg_ready;
  assign cfg_illegal = (i_cfg_div < DIV_W'(2));

  // NOTE: state registers use non-blocking assignments so every register in
  // this block sees the pre-edge values of the others, regardless of order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_cur_q  <= DIV_W'(DEFAULT_DIV);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      p_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      // p lags cnt by one cycle, so the last low slot of a period lands in
      // the cycle after the boundary and a stop or switch never cuts it short.
      p_q   <= (state_q == ST_RUN) && (cnt_q < half_w);

      if (cfg_fire) begin
        if (cfg_illegal) begin
          err_q <= 1'b1;
        end else if (state_q == ST_IDLE) begin
          // Nothing is running, so the ratio can take effect immediately.
          div_cur_q <= i_cfg_div;
        end else begin
          pend_q     <= 1'b1;
          pend_div_q <= i_cfg_div;
        end
      end

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          // A request accepted on the very edge that stopped the clock is
          // still applied through SWITCH.
          if (pend_q) begin
            state_q <= ST_SWITCH;
          end else if (i_en) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (pend_q) begin
              state_q <= ST_SWITCH;
            end else if (!i_en) begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        ST_SWITCH: begin
          div_cur_q <= pend_div_q;
          pend_q    <= 1'b0;
          cnt_q     <= '0;
          state_q   <= i_en ? ST_RUN : ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // NOTE: the falling-edge register needs the same asynchronous reset as the
  // rest, otherwise a reset during the high phase could leave o_clk_div high.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= p_q;
    end
  end

  // q only extends p by half a cycle; p and q never change on the same edge,
  // so the OR is glitch free.
  assign o_clk_div = p_q | (div_cur_q[0] & q_q);
  assign o_cfg_err = err_q;
  assign o_busy    = pend_q;
  assign o_div_cur = div_cur_q;

`ifdef CLK_DIV_STROBE_EN
  logic stb_q;

  // Same one-cycle lag as p, so the strobe coincides with the rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stb_q <= 1'b0;
    end else begin
      stb_q <= (state_q == ST_RUN) && (cnt_q == '0);
    end
  end

  assign o_period_stb = stb_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
`timescale 1ns/1ps

module tb_clk_div_sched;

  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 3;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             en        = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div   = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             busy;
  logic [DIV_W-1:0] div_cur;
  logic             clk_div;
`ifdef CLK_DIV_STROBE_EN
  logic             period_stb;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_div_sched #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_cfg_valid (cfg_valid),
    .i_cfg_div   (cfg_div),
    .o_cfg_ready (cfg_ready),
    .o_cfg_err   (cfg_err),
    .o_busy      (busy),
    .o_div_cur   (div_cur),
`ifdef CLK_DIV_STROBE_EN
    .o_period_stb(period_stb),
`endif
    .o_clk_div   (clk_div)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. The divided clock is described as a queue of half-cycle
  // levels: every period of ratio N is 2N half cycles, the first N high. Period
  // boundaries are tracked as absolute posedge numbers.
  // ---------------------------------------------------------------------------
  logic             mdl_on = 1'b0;
  logic             chk_en = 1'b0;
  logic             m_run, m_sw, m_pend, m_err;
  logic [DIV_W-1:0] m_pdiv, m_cur;
  int               m_pe, m_bnd;
  logic [1:0]       m_wave[$];   // {strobe, level} per half cycle
  logic             m_fire, m_legal;

  task automatic model_reset();
    m_run  = 1'b0;
    m_sw   = 1'b0;
    m_pend = 1'b0;
    m_err  = 1'b0;
    m_pdiv = '0;
    m_cur  = DIV_W'(DEFAULT_DIV);
    m_pe   = 0;
    m_bnd  = 0;
    m_wave.delete();
  endtask

  task automatic push_period(input int n);
    for (int i = 0; i < n; i++) m_wave.push_back({(i == 0), 1'b1});
    for (int i = 0; i < n; i++) m_wave.push_back(2'b00);
  endtask

  // Entering run: one low cycle, then periods back to back.
  task automatic start_run();
    m_run = 1'b1;
    m_bnd = m_pe + int'(m_cur);
    m_wave.push_back(2'b00);
    m_wave.push_back(2'b00);
    push_period(int'(m_cur));
  endtask

  always @(posedge clk) begin
    if (mdl_on) begin
      m_pe++;
      m_fire  = cfg_valid && !m_pend && !m_sw;
      m_legal = (cfg_div >= DIV_W'(2));
      m_err   = m_fire && !m_legal;
      if (m_sw) begin
        m_cur  = m_pdiv;
        m_pend = 1'b0;
        m_sw   = 1'b0;
        if (en) start_run();
      end else if (m_run) begin
        if (m_pe == m_bnd) begin
          if (m_pend) begin
            m_sw  = 1'b1;
            m_run = 1'b0;
          end else if (!en) begin
            m_run = 1'b0;
          end else begin
            m_bnd += int'(m_cur);
            push_period(int'(m_cur));
          end
        end
        if (m_fire && m_legal) begin
          m_pend = 1'b1;
          m_pdiv = cfg_div;
        end
      end else begin
        if (m_fire && m_legal) m_cur = cfg_div;
        if (m_pend) m_sw = 1'b1;
        else if (en) start_run();
      end
    end
  end

  // Single compare process: every half cycle for the clock, every posedge for
  // the handshake/status outputs.
  logic [1:0] exp_h;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (chk_en) begin
        exp_h = (m_wave.size() > 0) ? m_wave.pop_front() : 2'b00;
        check("clk_div_pos", 32'(clk_div), 32'(exp_h[0]));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend && !m_sw));
        check("busy", 32'(busy), 32'(m_pend));
        check("div_cur", 32'(div_cur), 32'(m_cur));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef CLK_DIV_STROBE_EN
        check("period_stb", 32'(period_stb), 32'(exp_h[1]));
`endif
      end
      @(negedge clk); #2;
      if (chk_en) begin
        exp_h = (m_wave.size() > 0) ? m_wave.pop_front() : 2'b00;
        check("clk_div_neg", 32'(clk_div), 32'(exp_h[0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Samples o_clk_div on nh consecutive half cycles, starting after the next
  // posedge; the first sample ends up in the most significant used bit.
  task automatic grab(input int nh, output logic [31:0] v);
    v = '0;
    @(posedge clk); #2;
    for (int i = 0; i < nh; i++) begin
      if (i > 0) begin
        if (i % 2 == 1) @(negedge clk);
        else            @(posedge clk);
        #2;
      end
      v = {v[30:0], clk_div};
    end
  endtask

  task automatic wait_level(input logic lvl, input int max_c, input string nm);
    int n;
    n = 0;
    tick();
    while (clk_div !== lvl && n < max_c) begin
      tick();
      n++;
    end
    check(nm, 32'(clk_div), 32'(lvl));
  endtask

  task automatic wait_idle_busy(input int max_c, input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_c) begin
      tick();
      n++;
    end
    check(nm, 32'(busy), 32'(0));
  endtask

  task automatic offer(input logic [DIV_W-1:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  logic [31:0] v;

  initial begin
    // Reset and release between edges.
    model_reset();
    #17;
    rst_n = 1'b1;
    #1;
    mdl_on = 1'b1;
    chk_en = 1'b1;
    check("rst_clk_div", 32'(clk_div), 32'(0));
    check("rst_ready", 32'(cfg_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_err", 32'(cfg_err), 32'(0));
    check("rst_div_cur", 32'(div_cur), 32'(3));

    // Default ratio 3: first rise one posedge after i_en is sampled, 1.5/1.5.
    en = 1'b1;
    grab(8, v);
    check("n3_start", v, 32'b00111000);
    grab(6, v);
    check("n3_period", v, 32'b111000);

    // Stop, then load 4 in IDLE via the fast path and restart.
    en = 1'b0;
    repeat (8) tick();
    offer(DIV_W'(4));
    check("idle_load_div", 32'(div_cur), 32'(4));
    check("idle_load_busy", 32'(busy), 32'(0));
    en = 1'b1;
    grab(10, v);
    check("n4_start", v, 32'b0011110000);
    grab(8, v);
    check("n4_period", v, 32'b11110000);

    // Switch to 5 through the RUN path, then request 2 mid-period.
    offer(DIV_W'(5));
    wait_idle_busy(20, "to5_busy_clear");
    wait_level(1'b0, 20, "n5_find_low");
    wait_level(1'b1, 20, "n5_find_rise");
    offer(DIV_W'(2));
    check("n5to2_busy", 32'(busy), 32'(1));
    check("n5to2_ready", 32'(cfg_ready), 32'(0));
    grab(14, v);
    check("n5to2_wave", v, 32'b10000000110011);
    check("n2_div_cur", 32'(div_cur), 32'(2));
    check("n2_busy", 32'(busy), 32'(0));

    // Illegal ratios 0 and 1 back to back.
    cfg_valid = 1'b1;
    cfg_div   = '0;
    tick();
    check("err0_pulse", 32'(cfg_err), 32'(1));
    cfg_div = DIV_W'(1);
    tick();
    check("err1_pulse", 32'(cfg_err), 32'(1));
    cfg_valid = 1'b0;
    tick();
    check("err_cleared", 32'(cfg_err), 32'(0));
    check("err_div_cur", 32'(div_cur), 32'(2));
    check("err_busy", 32'(busy), 32'(0));

    // Ratio 7: drop i_en at cnt=1, the period completes, then restart.
    offer(DIV_W'(7));
    wait_idle_busy(20, "to7_busy_clear");
    wait_level(1'b0, 30, "n7_find_low");
    wait_level(1'b1, 30, "n7_find_rise");
    en = 1'b0;
    grab(16, v);
    check("n7_stop", v, 32'b1111100000000000);
    repeat (5) tick();
    check("n7_stopped", 32'(clk_div), 32'(0));
    en = 1'b1;
    grab(16, v);
    check("n7_restart", v, 32'b0011111110000000);

    // Reset during the high phase with a change pending.
    wait_level(1'b0, 30, "rst_find_low");
    wait_level(1'b1, 30, "rst_find_rise");
    offer(DIV_W'(4));
    check("rst_pending", 32'(busy), 32'(1));
    #1;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    mdl_on = 1'b0;
    #1;
    check("rst_async_clk", 32'(clk_div), 32'(0));
    check("rst_async_div", 32'(div_cur), 32'(3));
    check("rst_async_busy", 32'(busy), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    model_reset();
    mdl_on = 1'b1;
    chk_en = 1'b1;
    check("rel_div_cur", 32'(div_cur), 32'(3));
    check("rel_ready", 32'(cfg_ready), 32'(1));
    grab(8, v);
    check("rel_n3_start", v, 32'b00111000);

    // Pending change and i_en falling at the same boundary: SWITCH, then IDLE.
    wait_level(1'b0, 20, "sim_find_low");
    wait_level(1'b1, 20, "sim_find_rise");
    en = 1'b0;
    offer(DIV_W'(6));
    repeat (6) tick();
    check("sim_div_cur", 32'(div_cur), 32'(6));
    check("sim_busy", 32'(busy), 32'(0));
    check("sim_clk_low", 32'(clk_div), 32'(0));
    check("sim_ready", 32'(cfg_ready), 32'(1));

    // Run the new ratio briefly under the model.
    en = 1'b1;
    grab(14, v);
    check("n6_start", v, 32'b00111111000000);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
